// File: rtl/debug_patgen.sv
// debug_patgen: programmable debug pattern generator with a prescaler.
// Ports:
//   clk      - clock; all state changes on its rising edge
//   rst      - synchronous active-high reset
//   en       - run enable; low freezes the prescaler and data0
//   mode     - pattern select (up, down, hold, LFSR, walking one)
//   div      - prescaler divisor; one step every div+1 enabled cycles
//   load     - single-cycle load strobe, writes load_val into data0
//   load_val - value loaded into data0
//   data0    - registered pattern output
//   tick     - pulse in the first cycle a stepped data0 value is visible
//   wrap     - pulse with tick when the step completed a pattern period
module debug_patgen #(
    parameter int               WIDTH     = 16,
    parameter int               DIV_W     = 8,
    parameter logic [WIDTH-1:0] LFSR_POLY = 16'hB400,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] data0,
    output logic             tick,
    output logic             wrap
);

    localparam logic [DIV_W-1:0] C_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] D_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] cnt;
    logic             step;
    logic [WIDTH-1:0] nxt;
    logic             nxt_wrap;

    // Counting past div (after div was lowered) runs on to all-ones,
    // which also steps, so the prescaler can never lock up.
    assign step = en && ((cnt == div) || (&cnt));

    always_comb begin
        nxt      = data0;
        nxt_wrap = 1'b0;
        case (mode)
            3'b000: begin
                nxt      = data0 + D_ONE;
                nxt_wrap = &data0;
            end
            3'b001: begin
                nxt      = data0 - D_ONE;
                nxt_wrap = ~|data0;
            end
            3'b011: begin
                // Zero is the LFSR lock-up state; reseed with 1.
                if (~|data0)
                    nxt = D_ONE;
                else
                    nxt = (data0 >> 1) ^ (data0[0] ? LFSR_POLY : '0);
                nxt_wrap = (nxt == D_ONE);
            end
            3'b100: begin
                if ($onehot(data0))
                    nxt = {data0[WIDTH-2:0], data0[WIDTH-1]};
                else
                    nxt = D_ONE;
                nxt_wrap = (nxt == D_ONE);
            end
            default: begin
                nxt      = data0;
                nxt_wrap = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data0 <= RST_VAL;
            cnt   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            data0 <= load_val;
            cnt   <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (step) begin
            data0 <= nxt;
            cnt   <= '0;
            tick  <= 1'b1;
            wrap  <= nxt_wrap;
        end else begin
            if (en)
                cnt <= cnt + C_ONE;
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_patgen.sv
// tb_debug_patgen: directed scenarios plus randomized stimulus checked
// every cycle against a behavioural model of the pattern generator.
module tb_debug_patgen;

    localparam logic [15:0] POLY = 16'hB400;
    localparam logic [15:0] RSTV = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  mode;
    logic [7:0]  div;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] data0;
    logic        tick;
    logic        wrap;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Model state
    int          m_cnt;
    logic [15:0] m_data;
    logic        m_tick;
    logic        m_wrap;

    debug_patgen #(
        .WIDTH(16), .DIV_W(8), .LFSR_POLY(POLY), .RST_VAL(RSTV)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .div(div),
        .load(load), .load_val(load_val),
        .data0(data0), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int popcount(input logic [15:0] d);
        int c = 0;
        for (int i = 0; i < 16; i++) if (d[i]) c++;
        return c;
    endfunction

    function automatic logic [15:0] next_pat(input logic [2:0] md,
                                             input logic [15:0] d);
        int v = int'(d);
        case (md)
            3'd0: v = (v + 1) % 65536;
            3'd1: v = (v + 65535) % 65536;
            3'd3: begin
                if (v == 0) v = 1;
                else v = (v / 2) ^ ((v % 2 == 1) ? int'(POLY) : 0);
            end
            3'd4: begin
                if (popcount(d) != 1) v = 1;
                else v = ((v * 2) % 65536) + (v / 32768);
            end
            default: v = int'(d);
        endcase
        return v[15:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_data = RSTV; m_cnt = 0; m_tick = 0; m_wrap = 0;
        end else if (load) begin
            m_data = load_val; m_cnt = 0; m_tick = 0; m_wrap = 0;
        end else if (!en) begin
            m_tick = 0; m_wrap = 0;
        end else if (m_cnt == int'(div) || m_cnt == 255) begin
            logic [15:0] nv;
            nv = next_pat(mode, m_data);
            case (mode)
                3'd0: m_wrap = (m_data == 16'hFFFF);
                3'd1: m_wrap = (m_data == 16'h0000);
                3'd3, 3'd4: m_wrap = (nv == 16'h0001);
                default: m_wrap = 0;
            endcase
            m_data = nv; m_cnt = 0; m_tick = 1;
        end else begin
            m_cnt++; m_tick = 0; m_wrap = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_data0", {16'h0, data0}, {16'h0, m_data});
            chk("model_tick", {31'h0, tick}, {31'h0, m_tick});
            chk("model_wrap", {31'h0, wrap}, {31'h0, m_wrap});
        end
    end

    task automatic nclk();
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [15:0] d,
                       input logic t, input logic w);
        chk({name, "_data0"}, {16'h0, data0}, {16'h0, d});
        chk({name, "_tick"}, {31'h0, tick}, {31'h0, t});
        chk({name, "_wrap"}, {31'h0, wrap}, {31'h0, w});
    endtask

    initial begin
        bit found;
        rst = 1; en = 0; load = 0; mode = 0; div = 0; load_val = 0;
        nclk(); nclk();
        chk_on = 1'b1;
        lit("reset", RSTV, 0, 0);

        // Free-running counter with div=0
        rst = 0; en = 1; mode = 3'd0; div = 8'd0;
        for (int i = 1; i <= 3; i++) begin
            nclk();
            lit("up_div0", 16'(i), 1, 0);
        end

        // Up count across the wrap with div=3
        load_val = 16'hFFFE; load = 1; div = 8'd3;
        nclk();
        lit("load_fffe", 16'hFFFE, 0, 0);
        load = 0;
        for (int i = 1; i <= 4; i++) begin
            nclk();
            if (i == 4) lit("up_ffff", 16'hFFFF, 1, 0);
        end
        for (int i = 1; i <= 4; i++) begin
            nclk();
            if (i == 4) lit("up_wrap", 16'h0000, 1, 1);
        end

        // LFSR from the zero lock-up state
        mode = 3'd3; load_val = 16'h0000; load = 1; div = 8'd0;
        nclk();
        load = 0;
        nclk(); lit("lfsr1", 16'h0001, 1, 1);
        nclk(); lit("lfsr2", 16'hB400, 1, 0);
        nclk(); lit("lfsr3", 16'h5A00, 1, 0);

        // Walking one from a non-one-hot value
        mode = 3'd4; load_val = 16'h0005; load = 1;
        nclk();
        load = 0;
        nclk(); lit("walk_first", 16'h0001, 1, 1);
        for (int i = 1; i < 16; i++) nclk();
        lit("walk_top", 16'h8000, 1, 0);
        nclk(); lit("walk_wrap", 16'h0001, 1, 1);

        // Reset one cycle after a step, mid-prescale
        mode = 3'd0; div = 8'd2; load_val = 16'h0010; load = 1;
        nclk();
        load = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            nclk();
            if (tick) found = 1;
        end
        chk("step_seen", {31'h0, found}, 32'h1);
        rst = 1;
        nclk(); lit("rst_mid", RSTV, 0, 0);
        rst = 0;
        nclk(); lit("rst_gap1", RSTV, 0, 0);
        nclk(); lit("rst_gap2", RSTV, 0, 0);
        nclk(); lit("rst_step", RSTV + 16'h1, 1, 0);

        // Load beats a coincident step; then disabled hold
        div = 8'd0; load_val = 16'h1234; load = 1;
        nclk(); lit("load_prio", 16'h1234, 0, 0);
        load = 0; en = 0;
        for (int i = 0; i < 5; i++) begin
            nclk();
            lit("en_off", 16'h1234, 0, 0);
        end

        // Raise div, then lower it below the running count
        en = 1; mode = 3'd1; div = 8'd200;
        repeat (20) nclk();
        div = 8'd3;
        repeat (260) nclk();

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 29) == 0);
            en   = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 7) == 0) mode = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: load_val = 16'h1 << $urandom_range(0, 15);
                1: load_val = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0;
                default: load_val = 16'($urandom);
            endcase
            if (i % 60 == 0) begin
                case ($urandom_range(0, 5))
                    0: div = 8'd255;
                    1: div = 8'($urandom_range(10, 30));
                    default: div = 8'($urandom_range(0, 4));
                endcase
            end
            nclk();
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
